// File: rtl/bank_scheduler_if.sv
// Packet type shared by the bank and its nodes, plus the bundled mesh/node port
// interface of one bank. The scheduler binds the slave side.
package bank_scheduler_pkg;
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] z;
    } addr_t;

    typedef struct packed {
        addr_t       addr;
        logic [31:0] data;
    } pkt_t;
endpackage

interface bank_scheduler_if #(parameter int NUM_NODES = 4);
    import bank_scheduler_pkg::*;

    logic                            in_valid;
    logic                            in_ready;
    pkt_t                            in_pkt;
    logic [NUM_NODES-1:0]            node_in_valid;
    logic [NUM_NODES-1:0]            node_in_ready;
    pkt_t                            node_in_pkt;
    logic [NUM_NODES-1:0]            node_out_valid;
    logic [NUM_NODES-1:0]            node_out_ready;
    pkt_t [NUM_NODES-1:0]            node_out_pkt;
    logic                            out_valid;
    logic                            out_ready;
    pkt_t                            out_pkt;

    modport slave (
        input  in_valid, in_pkt, node_in_ready, node_out_valid, node_out_pkt, out_ready,
        output in_ready, node_in_valid, node_in_pkt, node_out_ready, out_valid, out_pkt
    );

    modport master (
        output in_valid, in_pkt, node_in_ready, node_out_valid, node_out_pkt, out_ready,
        input  in_ready, node_in_valid, node_in_pkt, node_out_ready, out_valid, out_pkt
    );
endinterface

// File: rtl/bank_scheduler.sv
// One bank's mesh port shared by NUM_NODES nodes: address-decoded ingress fan-out
// and round-robin egress into a single registered output slot.
module bank_sched_lane #(
    parameter int PTR_W = 2,
    parameter int IDX   = 0
) (
    input  logic [3:0]       z,
    input  logic [PTR_W-1:0] ptr,
    input  logic             in_valid,
    input  logic             accept_en,
    input  logic             node_in_ready,
    output logic             node_in_valid,
    output logic             ready_sel,
    output logic             node_out_ready
);
    logic sel;

    assign sel            = (z == 4'(IDX));
    assign node_in_valid  = in_valid && sel;
    assign ready_sel      = sel && node_in_ready;
    // Grant depends only on ptr and slot state, never on node valids.
    assign node_out_ready = (ptr == PTR_W'(IDX)) && accept_en;
endmodule

module bank_scheduler #(
    parameter int NUM_NODES  = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bank_scheduler_if.slave       bus,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    import bank_scheduler_pkg::*;

    localparam int PTR_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

    logic [PTR_W-1:0]     ptr;
    logic                 accept_en;
    logic                 hit;
    logic                 take;
    logic [NUM_NODES-1:0] lane_in_valid;
    logic [NUM_NODES-1:0] lane_rdy;
    logic [NUM_NODES-1:0] lane_grant;
    logic                 out_valid;
    pkt_t                 out_pkt;

    assign hit       = int'(bus.in_pkt.addr.z) < NUM_NODES;
    assign accept_en = !out_valid || bus.out_ready;
    assign take      = |(bus.node_out_valid & lane_grant);

    for (genvar i = 0; i < NUM_NODES; i++) begin : g_lane
        bank_sched_lane #(.PTR_W(PTR_W), .IDX(i)) u_lane (
            .z             (bus.in_pkt.addr.z),
            .ptr           (ptr),
            .in_valid      (bus.in_valid),
            .accept_en     (accept_en),
            .node_in_ready (bus.node_in_ready[i]),
            .node_in_valid (lane_in_valid[i]),
            .ready_sel     (lane_rdy[i]),
            .node_out_ready(lane_grant[i])
        );
    end

    assign bus.node_in_valid  = lane_in_valid;
    assign bus.node_in_pkt    = bus.in_pkt;
    // Misaddressed packets are swallowed so they cannot wedge the mesh.
    assign bus.in_ready       = !hit || (|lane_rdy);
    assign bus.node_out_ready = lane_grant;
    assign bus.out_valid      = out_valid;
    assign bus.out_pkt        = out_pkt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_pkt   <= '0;
            drop_cnt  <= '0;
        end else begin
            // Pointer rotates on every open slot cycle, transfer or not.
            if (accept_en)
                ptr <= (ptr == PTR_W'(NUM_NODES-1)) ? '0 : ptr + 1'b1;
            if (take) begin
                out_valid <= 1'b1;
                out_pkt   <= bus.node_out_pkt[ptr];
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
            if (bus.in_valid && !hit && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule
